// File: rtl/serial_space_controller_pkg.sv
// Shared definitions for the parking-counter blocks: FSM state and operation
// encodings plus the WIDTH/CAPACITY legality helpers.
package serial_space_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    typedef enum logic {
        OP_ENTRY = 1'b0,
        OP_EXIT  = 1'b1
    } op_t;

    // CAPACITY must fit in the count and leave room for a non-empty lot.
    function automatic bit capacity_is_legal(input int width, input int capacity);
        return (width >= 1) && (width <= 31) &&
               (capacity >= 1) && (capacity <= ((1 << width) - 1));
    endfunction

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_space_controller_full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module serial_space_controller_full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_space_controller.sv
// Parking-lot free-space counter updated bit-serially through one full
// subtractor: entry subtracts 1, exit subtracts 2^WIDTH-1 (i.e. adds 1).
module serial_space_controller
    import serial_space_controller_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CAPACITY = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    output logic [WIDTH-1:0] free_count,
    output logic             full,
    output logic             busy,
    output logic             entry_ack,
    output logic             exit_ack,
    output logic             entry_deny,
    output logic             exit_deny
);

    localparam int                IDX_W    = idx_width(WIDTH);
    localparam logic [WIDTH-1:0]  CAP_VAL  = WIDTH'(CAPACITY);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

    generate
        if (!capacity_is_legal(WIDTH, CAPACITY)) begin : g_bad_params
            $error("serial_space_controller: CAPACITY must be in 1..2^WIDTH-1");
        end
    endgenerate

    state_t             r_state;
    op_t                r_op;
    logic [WIDTH-1:0]   r_work;
    logic               r_borrow;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [WIDTH-1:0]   r_count;
    logic               r_full;
    logic               r_busy;
    logic               r_entry_ack;
    logic               r_exit_ack;
    logic               r_entry_deny;
    logic               r_exit_deny;

    logic               w_sub_bit;
    logic               w_diff;
    logic               w_borrow_out;
    logic [WIDTH-1:0]   w_work_shifted;

    // Entry subtracts ...0001; exit subtracts ...1111, which is +1 modulo 2^WIDTH.
    assign w_sub_bit = (r_op == OP_EXIT) | (r_bit_idx == '0);

    serial_space_controller_full_subtractor u_fsub (
        .i_a    (r_work[0]),
        .i_b    (w_sub_bit),
        .i_bin  (r_borrow),
        .o_diff (w_diff),
        .o_bout (w_borrow_out)
    );

    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_work_shifted = w_diff;
        end else begin : g_shift_wn
            assign w_work_shifted = {w_diff, r_work[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_ENTRY;
            r_work       <= '0;
            r_borrow     <= 1'b0;
            r_bit_idx    <= '0;
            r_count      <= CAP_VAL;
            r_full       <= 1'b0;
            r_busy       <= 1'b0;
            r_entry_ack  <= 1'b0;
            r_exit_ack   <= 1'b0;
            r_entry_deny <= 1'b0;
            r_exit_deny  <= 1'b0;
        end else begin
            r_entry_ack  <= 1'b0;
            r_exit_ack   <= 1'b0;
            r_entry_deny <= 1'b0;
            r_exit_deny  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Exit has priority; a simultaneous entry simply stays pending.
                    if (exit_req) begin
                        if (r_count == CAP_VAL) begin
                            r_exit_deny <= 1'b1;
                        end else begin
                            r_work    <= r_count;
                            r_borrow  <= 1'b0;
                            r_bit_idx <= '0;
                            r_op      <= OP_EXIT;
                            r_state   <= ST_SHIFT;
                            r_busy    <= 1'b1;
                        end
                    end else if (entry_req) begin
                        if (r_count == '0) begin
                            r_entry_deny <= 1'b1;
                        end else begin
                            r_work    <= r_count;
                            r_borrow  <= 1'b0;
                            r_bit_idx <= '0;
                            r_op      <= OP_ENTRY;
                            r_state   <= ST_SHIFT;
                            r_busy    <= 1'b1;
                        end
                    end
                end

                ST_SHIFT: begin
                    r_work   <= w_work_shifted;
                    r_borrow <= w_borrow_out;
                    if (r_bit_idx == LAST_IDX) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                    end
                end

                ST_COMMIT: begin
                    // Final borrow is intentionally dropped: arithmetic is modulo 2^WIDTH.
                    r_count <= r_work;
                    r_full  <= (r_work == '0);
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (r_op == OP_EXIT) begin
                        r_exit_ack <= 1'b1;
                    end else begin
                        r_entry_ack <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign free_count = r_count;
    assign full       = r_full;
    assign busy       = r_busy;
    assign entry_ack  = r_entry_ack;
    assign exit_ack   = r_exit_ack;
    assign entry_deny = r_entry_deny;
    assign exit_deny  = r_exit_deny;

endmodule
